mem_access_stage: RTL
=====================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter TIMEOUT, default 16, maximum number of BUSY cycles waiting for dmem_ready (legal range 1..255).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports as below:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset; asserted when 0.
- MEM_alu_out  in  XLEN  ALU result or load/store byte address.
- MEM_b2  in  XLEN  store data.
- MEM_rd  in  5  destination register.
- MEM_we  in  1  register write enable.
- MEM_ld  in  1  load instruction.
- MEM_str  in  1  store instruction.
- dmem_req  out  1  memory request valid.
- dmem_wr  out  1  1 = write, 0 = read; valid while dmem_req=1.
- dmem_addr  out  XLEN  word address; bits [1:0] are always 0.
- dmem_wdata  out  XLEN  store data.
- dmem_ready  in  1  memory accepts/completes the current request this cycle.
- dmem_rdata  in  XLEN  read data; valid when dmem_ready=1 on a read.
- mem_stall  out  1  upstream stages hold their registers.
- mem_err  out  1  one-cycle pulse on access timeout.
- WB_result  out  XLEN  registered writeback value.
- WB_rd  out  5  registered destination register.
- WB_we  out  1  registered writeback enable.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-005 access = MEM_ld | MEM_str. If both are 1, the instruction SHALL be treated as a load.
REQ-006 IDLE with access=1: mem_stall=1 combinationally. Next state is BUSY. The block latches addr={MEM_alu_out[XLEN-1:2],2'b00}, wdata=MEM_b2 and wr=MEM_str&~MEM_ld, and clears the timeout counter.
REQ-007 IDLE with access=0: mem_stall=0. WB_result<=MEM_alu_out, WB_rd<=MEM_rd, WB_we<=MEM_we&(MEM_rd!=0).
REQ-008 BUSY: dmem_req=1 (registered, glitch-free), and dmem_addr, dmem_wr and dmem_wdata are held stable. mem_stall=1 and the counter increments each cycle.
REQ-009 BUSY with dmem_ready=1: next state is DONE. On a read, dmem_rdata is latched into the load buffer.
REQ-010 BUSY with dmem_ready=0 and counter==TIMEOUT-1: dmem_req drops, next state is DONE, and an error flag is set.
REQ-011 DONE: dmem_req=0 and mem_stall=0. Next state is IDLE. The WB registers load on this edge:
- load, no error: WB_result=load buffer, WB_rd=MEM_rd, WB_we=MEM_we&(MEM_rd!=0).
- store, or any error: WB_we=0, WB_rd=MEM_rd, WB_result=MEM_alu_out.
REQ-012 mem_err SHALL be 1 only in the DONE cycle that follows a timeout.
REQ-013 During the IDLE-detect cycle and all BUSY cycles, the WB registers SHALL capture a bubble: WB_we=0 and WB_result/WB_rd unchanged.
REQ-014 Latency: the minimum memory access stalls 2 cycles (IDLE-detect plus one BUSY cycle). WB outputs are valid in the cycle after DONE.
REQ-015 dmem_ready SHALL be ignored outside BUSY.
REQ-016 Inputs are not re-sampled in BUSY. Inputs are assumed stable while mem_stall=1.
REQ-017 Back-to-back accesses: after DONE the FSM returns to IDLE, and a new access there stalls per REQ-006.

Reset
REQ-018 While rst=0, asynchronously:
- state=IDLE.
- dmem_req=0, dmem_wr=0, dmem_addr=0, dmem_wdata=0.
- counter=0, error flag=0, mem_err=0.
- WB_result=0, WB_rd=0, WB_we=0.
REQ-019 Reset asserted mid-BUSY SHALL drop dmem_req in the same cycle, and the access is abandoned. After rst rises, the first edge evaluates IDLE.

Verification
REQ-020 ALU pass-through: MEM_alu_out=0x1234, MEM_rd=5, MEM_we=1, no ld/str -> next cycle WB_result=0x1234, WB_rd=5, WB_we=1, mem_stall=0 throughout.
REQ-021 Load with a zero-wait memory:
- Stimulus: MEM_ld=1, addr 0x103, rd=7, we=1; dmem_ready=1 in the first BUSY cycle, rdata=0xCAFEF00D.
- Response: dmem_addr=0x100; mem_stall high for exactly 2 cycles; after DONE, WB_result=0xCAFEF00D and WB_we=1.
REQ-022 Store with ready after 3 BUSY cycles: MEM_str=1, MEM_b2=0xA5A5A5A5 -> dmem_wr=1 and wdata stable for 3 cycles; stall lasts 4 cycles; WB_we=0 after DONE.
REQ-023 Timeout: load with dmem_ready held 0, TIMEOUT=16 -> dmem_req high for 16 cycles then low; mem_err pulses once; WB_we=0.
REQ-024 Load to x0: rd=0 -> WB_we=0. A late dmem_ready arriving in IDLE -> no effect.
REQ-025 Reset mid-operation: rst=0 in the 2nd BUSY cycle -> dmem_req=0 and all outputs 0 immediately. After release, a normal ALU op passes per REQ-020.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: ALU results pass straight to writeback, loads
// and stores run a single IDLE/BUSY/DONE handshake against the data memory with
// a bounded wait (TIMEOUT busy cycles) and stall the upstream stages meanwhile.
// Latency: ALU op 1 cycle to WB; memory op stalls 1 + N busy cycles, WB valid after DONE.
// Backpressure: mem_stall holds upstream; dmem_ready is the only memory-side handshake.
// Ports: clk/rst (async active-low); MEM_* instruction inputs; dmem_* memory request
// interface; mem_stall, mem_err status; WB_* registered writeback outputs.
module mem_access_stage #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] MEM_alu_out,
  input  logic [XLEN-1:0] MEM_b2,
  input  logic [4:0]      MEM_rd,
  input  logic            MEM_we,
  input  logic            MEM_ld,
  input  logic            MEM_str,
  output logic            dmem_req,
  output logic            dmem_wr,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            mem_stall,
  output logic            mem_err,
  output logic [XLEN-1:0] WB_result,
  output logic [4:0]      WB_rd,
  output logic            WB_we
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Last busy-cycle count before giving up on the memory.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]      state_q,     state_d;
  logic            req_q,       req_d;
  logic            wr_q,        wr_d;
  logic [XLEN-1:0] addr_q,      addr_d;
  logic [XLEN-1:0] wdata_q,     wdata_d;
  logic [7:0]      cnt_q,       cnt_d;
  logic            err_q,       err_d;
  logic [XLEN-1:0] ldbuf_q,     ldbuf_d;
  logic [XLEN-1:0] wb_result_q, wb_result_d;
  logic [4:0]      wb_rd_q,     wb_rd_d;
  logic            wb_we_q,     wb_we_d;

  logic access;
  logic rd_nz;

  assign access = MEM_ld | MEM_str;
  assign rd_nz  = (MEM_rd != 5'd0);

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    ldbuf_d     = ldbuf_q;
    wb_result_d = wb_result_q;
    wb_rd_d     = wb_rd_q;
    wb_we_d     = 1'b0;   // bubble unless a branch below retires an instruction

    case (state_q)
      IDLE: begin
        if (access) begin
          state_d = BUSY;
          req_d   = 1'b1;
          // A combined ld/str encoding is resolved as a load.
          wr_d    = MEM_str & ~MEM_ld;
          addr_d  = {MEM_alu_out[XLEN-1:2], 2'b00};
          wdata_d = MEM_b2;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
        end else begin
          wb_result_d = MEM_alu_out;
          wb_rd_d     = MEM_rd;
          wb_we_d     = MEM_we & rd_nz;
        end
      end

      BUSY: begin
        cnt_d = cnt_q + 8'd1;
        // A ready in the final allowed cycle still counts as success.
        if (dmem_ready) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!wr_q) begin
            ldbuf_d = dmem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        wb_rd_d = MEM_rd;
        if (!wr_q && !err_q) begin
          wb_result_d = ldbuf_q;
          wb_we_d     = MEM_we & rd_nz;
        end else begin
          wb_result_d = MEM_alu_out;
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= 8'd0;
      err_q       <= 1'b0;
      ldbuf_q     <= '0;
      wb_result_q <= '0;
      wb_rd_q     <= 5'd0;
      wb_we_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      ldbuf_q     <= ldbuf_d;
      wb_result_q <= wb_result_d;
      wb_rd_q     <= wb_rd_d;
      wb_we_q     <= wb_we_d;
    end
  end

  // Stall covers the detect cycle and every busy cycle; DONE lets upstream advance.
  assign mem_stall  = ((state_q == IDLE) & access) | (state_q == BUSY);
  // The error flag survives into DONE only; outside DONE it is masked.
  assign mem_err    = (state_q == DONE) & err_q;
  assign dmem_req   = req_q;
  assign dmem_wr    = wr_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign WB_result  = wb_result_q;
  assign WB_rd      = wb_rd_q;
  assign WB_we      = wb_we_q;

endmodule
